max7219_rx: RTL
===============

MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for the three serial inputs; legal range 2-3.
REQ-002 The block SHALL have port i_clk  input  1  system clock; the only clock in the block.
REQ-003 The block SHALL have port i_reset_n  input  1  reset; asynchronous assert, active-low.
REQ-004 The block SHALL have port i_serial_din  input  1  serial data, MSB first, asynchronous to i_clk.
REQ-005 The block SHALL have port i_serial_clk  input  1  serial shift clock, sampled on its rising edge, asynchronous to i_clk.
REQ-006 The block SHALL have port i_serial_load  input  1  frame latch; low while shifting, rising edge commits the frame.
REQ-007 The block SHALL have ports o_digit0..o_digit7  output  8 each  digit registers, addresses 0x1..0x8.
REQ-008 The block SHALL have port o_decode_mode  output  8  register at address 0x9.
REQ-009 The block SHALL have port o_intensity  output  4  register at address 0xA, data bits [3:0].
REQ-010 The block SHALL have port o_scan_limit  output  3  register at address 0xB, data bits [2:0].
REQ-011 The block SHALL have port o_shutdown_n  output  1  register at address 0xC, data bit 0; 0 = shutdown.
REQ-012 The block SHALL have port o_display_test  output  1  register at address 0xF, data bit 0.
REQ-013 The block SHALL have port o_frame_stb  output  1  one-cycle pulse when a valid frame commits.
REQ-014 The block SHALL have port o_frame_err  output  1  one-cycle pulse when a short frame is rejected.

Function
REQ-015 The block SHALL pass each serial input through its own SYNC_STAGES-flop synchroniser, then a 1-flop delay for edge detection.
REQ-016 On a synchronised rising edge of i_serial_clk while synchronised load is low, the block SHALL shift din into bit 0 of a 16-bit shift register and increment a 5-bit bit counter saturating at 17.
REQ-017 Serial clock edges while synchronised load is high SHALL be ignored: no shift, no count.
REQ-018 On a synchronised rising edge of load with bit count >= 16, the block SHALL decode the last 16 bits shifted in: address = bits[11:8], data = bits[7:0], bits[15:12] don't-care.
REQ-019 A committed frame SHALL update only the addressed register, at the edge after load-rise detection: SYNC_STAGES+1 i_clk edges after the first edge sampling raw load high.
REQ-020 Address 0x0 (no-op) and addresses 0xD and 0xE SHALL change no register but still pulse o_frame_stb.
REQ-021 On load rising edge with bit count < 16, the block SHALL change no register, pulse o_frame_err for one cycle, and SHALL NOT pulse o_frame_stb.
REQ-022 The bit counter SHALL clear on every synchronised load rising edge, valid or not; the shift register is not cleared.
REQ-023 If a serial clock rise and a load rise are detected in the same cycle, the shift SHALL occur first; the new bit SHALL count toward the frame being committed.
REQ-024 Correct reception SHALL require i_serial_clk high and low phases, and load-low-to-first-clock setup, each >= SYNC_STAGES+1 i_clk periods; din SHALL be stable for that window around each serial clock rise.
REQ-025 o_frame_stb and o_frame_err SHALL never both be high in the same cycle.

Reset
REQ-026 While i_reset_n is low, the following SHALL be cleared asynchronously to 0: all synchroniser flops, the shift register, the bit counter, o_digit0..7, o_decode_mode, o_intensity, o_scan_limit, o_shutdown_n, o_display_test, o_frame_stb and o_frame_err.
REQ-027 A frame in progress when reset asserts SHALL be discarded; after release, the first load rise SHALL see bit count 0 unless new clocks arrive.
REQ-028 After reset release, synchroniser flops at 0 SHALL NOT generate spurious edges; an input already high causes exactly one rising-edge detection.

Verification
REQ-029 Shift 0x037E, raise load -> o_digit2=0x7E one commit later, all other registers unchanged, o_frame_stb pulses once.
REQ-030 Shift 0x0C01 then 0x0A0F -> o_shutdown_n=1, o_intensity=0xF; then 0x0000 -> registers unchanged, o_frame_stb pulses.
REQ-031 Shift only 15 bits, raise load -> o_frame_err pulses once, no register changes; next 16-bit frame 0x0855 -> o_digit7=0x55.
REQ-032 Shift 17 bits 1_0x0103 -> last 16 bits are used, o_digit0=0x03, o_frame_stb pulses.
REQ-033 Assert i_reset_n low after 8 bits of a frame, release, shift 0x0B07 -> o_scan_limit=7; all other outputs at reset values.
REQ-034 Write all 8 digit addresses from a serial-driver instance through its o_serial_dout/o_serial_load/o_serial_clk outputs -> each o_digitN matches the value the driver transmitted.

Source files
------------

// File: rtl/max7219_rx.sv
// MAX7219-style serial register receiver: synchronises the three serial pins into
// the system clock domain and commits 16-bit frames into the display registers.
module max7219_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_din,
    input  logic       i_serial_clk,
    input  logic       i_serial_load,
    output logic [7:0] o_digit0,
    output logic [7:0] o_digit1,
    output logic [7:0] o_digit2,
    output logic [7:0] o_digit3,
    output logic [7:0] o_digit4,
    output logic [7:0] o_digit5,
    output logic [7:0] o_digit6,
    output logic [7:0] o_digit7,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test,
    output logic       o_frame_stb,
    output logic       o_frame_err
);

    logic [SYNC_STAGES-1:0] din_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] load_sync_q;
    logic                   sclk_dly_q;
    logic                   load_dly_q;

    logic                   din_s, sclk_s, load_s;
    logic                   sclk_rise, load_rise, shift_en;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d, cnt_shifted;
    logic [7:0]  digit_q [8];
    logic [7:0]  digit_d [8];
    logic [7:0]  decode_q, decode_d;
    logic [3:0]  intensity_q, intensity_d;
    logic [2:0]  scan_q, scan_d;
    logic        shutdown_n_q, shutdown_n_d;
    logic        test_q, test_d;
    logic        stb_q, stb_d;
    logic        err_q, err_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            din_sync_q  <= '0;
            sclk_sync_q <= '0;
            load_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            load_dly_q  <= 1'b0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], i_serial_din};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], i_serial_load};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            load_dly_q  <= load_sync_q[SYNC_STAGES-1];
        end
    end

    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign load_s    = load_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign load_rise = load_s & ~load_dly_q;
    // A clock edge coinciding with the load edge still belongs to the closing frame.
    assign shift_en  = sclk_rise & (~load_s | load_rise);

    always_comb begin
        shift_d      = shift_q;
        cnt_shifted  = cnt_q;
        digit_d      = digit_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_d       = scan_q;
        shutdown_n_d = shutdown_n_q;
        test_d       = test_q;
        stb_d        = 1'b0;
        err_d        = 1'b0;

        if (shift_en) begin
            shift_d = {shift_q[14:0], din_s};
            if (cnt_q != 5'd17) begin
                cnt_shifted = cnt_q + 5'd1;
            end
        end
        cnt_d = cnt_shifted;

        if (load_rise) begin
            cnt_d = '0;
            if (cnt_shifted >= 5'd16) begin
                stb_d = 1'b1;
                case (shift_d[11:8])
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_d[shift_d[10:8] - 3'd1] = shift_d[7:0];
                    4'h9:    decode_d     = shift_d[7:0];
                    4'hA:    intensity_d  = shift_d[3:0];
                    4'hB:    scan_d       = shift_d[2:0];
                    4'hC:    shutdown_n_d = shift_d[0];
                    4'hF:    test_d       = shift_d[0];
                    default: ;
                endcase
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            digit_q      <= '{default: '0};
            decode_q     <= '0;
            intensity_q  <= '0;
            scan_q       <= '0;
            shutdown_n_q <= 1'b0;
            test_q       <= 1'b0;
            stb_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            decode_q     <= decode_d;
            intensity_q  <= intensity_d;
            scan_q       <= scan_d;
            shutdown_n_q <= shutdown_n_d;
            test_q       <= test_d;
            stb_q        <= stb_d;
            err_q        <= err_d;
        end
    end

    assign o_digit0       = digit_q[0];
    assign o_digit1       = digit_q[1];
    assign o_digit2       = digit_q[2];
    assign o_digit3       = digit_q[3];
    assign o_digit4       = digit_q[4];
    assign o_digit5       = digit_q[5];
    assign o_digit6       = digit_q[6];
    assign o_digit7       = digit_q[7];
    assign o_decode_mode  = decode_q;
    assign o_intensity    = intensity_q;
    assign o_scan_limit   = scan_q;
    assign o_shutdown_n   = shutdown_n_q;
    assign o_display_test = test_q;
    assign o_frame_stb    = stb_q;
    assign o_frame_err    = err_q;

endmodule
